// File: rtl/dsbpm_ddr_pkg.sv
// rtl/dsbpm_ddr_pkg.sv - shared DDR write-path types, AXI constants and sizing helper
//
// Contents:
//   wr_state_t  arbiter state encoding (IDLE, ADDR, DATA, RESP)
//   BURST_INCR  AXI4 AWBURST code for incrementing bursts
//   RESP_OKAY   AXI4 BRESP code for a normal completion
//   clog2()     ceiling log2, used for beat-size and alignment widths
package dsbpm_ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// rtl/ddr_wr_arbiter_if.sv - AXI4 write-only bus (AW, W, B) between arbiter and DDR slave
//
// Parameters: ADDR_W byte address width, DATA_W write data width.
// Modports:
//   master  drives AW/W payload+valid and bready; samples awready, wready, bresp, bvalid
//   slave   the mirror image (DDR controller or bench model)
interface ddr_wr_arbiter_if #(
    parameter int ADDR_W = 35,
    parameter int DATA_W = 256
);

    logic [ADDR_W-1:0]   m_awaddr;
    logic [7:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_awvalid;
    logic                m_awready;

    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready;

    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;

    modport master (
        output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
//
// Ports:
//   req         request vector
//   ptr         search start index (must be < NUM_REQ)
//   gnt_onehot  one-hot winner (zero when no request)
//   gnt_idx     binary winner index (zero when no request)
//   gnt_valid   at least one request present
module rr_arbiter
    import dsbpm_ddr_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        int pos;
        pos        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit is the last write.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = int'(ptr) + off;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req[pos]) begin
                gnt_idx   = IDX_W'(pos);
                gnt_valid = 1'b1;
            end
        end
        if (gnt_valid) begin
            gnt_onehot[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// rtl/ddr_wr_arbiter.sv - round-robin sharing of one AXI4 write port among burst recorders
//
// Ports:
//   clk, resetn   AXI clock, asynchronous active-low reset
//   req_valid     per-requester burst request (held until req_ack)
//   req_addr      per-requester burst start byte address (packed slices)
//   req_ack       pulse on the AW handshake of the granted requester
//   wr_data       per-requester beat data (packed slices)
//   wr_valid      per-requester beat valid
//   wr_ready      beat accepted; only the granted requester can see it high
//   done          pulse on the B handshake of the granted requester
//   err           sticky SLVERR/DECERR flag per requester
//   err_clr       clears err[i]; wins over a simultaneous set
//   axi           AXI4 write master (AW, W, B)
module ddr_wr_arbiter
    import dsbpm_ddr_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 35,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int BURST_LEN      = 16
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]                  req_ack,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [NUM_REQ-1:0]                  wr_valid,
    output logic [NUM_REQ-1:0]                  wr_ready,
    output logic [NUM_REQ-1:0]                  done,
    output logic [NUM_REQ-1:0]                  err,
    input  logic [NUM_REQ-1:0]                  err_clr,
    ddr_wr_arbiter_if.master                    axi
);

    localparam int IDX_W   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int CNT_W   = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
    // A whole burst is a power-of-two number of bytes; clearing these bits
    // aligns it naturally, which also keeps it inside one 4 KB page.
    localparam int ALIGN_W = clog2(BURST_LEN * AXI_DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0]          LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
        ~((AXI_ADDR_WIDTH'(1) << ALIGN_W) - AXI_ADDR_WIDTH'(1));
    localparam logic [IDX_W-1:0]          LAST_IDX   = IDX_W'(NUM_REQ - 1);

    wr_state_t state, state_nxt;

    logic [IDX_W-1:0]          grant;
    logic [NUM_REQ-1:0]        grant_oh;
    logic [IDX_W-1:0]          ptr;
    logic [CNT_W-1:0]          beat_cnt;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;

    logic [NUM_REQ-1:0]        arb_onehot;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_valid;

    logic                      aw_fire;
    logic                      w_fire;
    logic                      b_fire;
    logic                      last_beat;
    logic                      resp_err;

    logic [AXI_ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
    logic [AXI_DATA_WIDTH-1:0] data_slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_slice[g] = req_addr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign data_slice[g] = wr_data[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    assign axi.m_awaddr  = awaddr_q;
    assign axi.m_awlen   = 8'(BURST_LEN - 1);
    assign axi.m_awsize  = 3'(clog2(AXI_DATA_WIDTH / 8));
    assign axi.m_awburst = BURST_INCR;
    assign axi.m_wstrb   = '1;

    assign last_beat = (beat_cnt == LAST_BEAT);
    // EXOKAY (2'b01) is a success; only codes with bit 1 set are failures.
    assign resp_err  = (axi.m_bresp != RESP_OKAY) && axi.m_bresp[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ack       = '0;
        wr_ready      = '0;
        done          = '0;
        aw_fire       = 1'b0;
        w_fire        = 1'b0;
        b_fire        = 1'b0;
        axi.m_awvalid = 1'b0;
        axi.m_wdata   = '0;
        axi.m_wvalid  = 1'b0;
        axi.m_wlast   = 1'b0;
        axi.m_bready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                axi.m_awvalid = 1'b1;
                if (axi.m_awready) begin
                    aw_fire   = 1'b1;
                    req_ack   = grant_oh;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // Pure mux: the granted requester sees the slave's ready directly.
                axi.m_wdata  = data_slice[grant];
                axi.m_wvalid = wr_valid[grant];
                axi.m_wlast  = last_beat;
                wr_ready     = grant_oh & {NUM_REQ{axi.m_wready}};
                w_fire       = wr_valid[grant] && axi.m_wready;
                if (w_fire && last_beat) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                axi.m_bready = 1'b1;
                if (axi.m_bvalid) begin
                    b_fire    = 1'b1;
                    done      = grant_oh;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant    <= '0;
            grant_oh <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
            awaddr_q <= '0;
            err      <= '0;
        end else begin
            // Grant is frozen here, so a requester that drops req_valid
            // after this point is still served.
            if (state == ST_IDLE && arb_valid) begin
                grant    <= arb_idx;
                grant_oh <= arb_onehot;
                awaddr_q <= addr_slice[arb_idx] & ALIGN_MASK;
            end

            if (aw_fire) begin
                beat_cnt <= '0;
            end else if (w_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (b_fire) begin
                ptr <= (grant == LAST_IDX) ? '0 : grant + IDX_W'(1);
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (err_clr[i]) begin
                    err[i] <= 1'b0;
                end else if (b_fire && resp_err && grant_oh[i]) begin
                    err[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Round-robin arbiter that shares the single DDR4 AXI4 write port between the waveform recorders (ADC I/Q recorders, magnitude recorder, and so on). Each requester asks for one fixed-length INCR burst at a time. The arbiter then:
- issues the AXI write-address (AW) transfer for the granted requester;
- steers that requester's data beats onto the write-data (W) channel;
- waits for the write response (B);
- releases the port to the next requester.

It sits between the recorder instances and the DDR4 MIG AXI slave, in the AXI clock domain.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- AXI_ADDR_WIDTH, 35, byte address width
- AXI_DATA_WIDTH, 256, W data width in bits
- BURST_LEN, 16, beats per burst (1..256)

Ports:
- clk  in  1  AXI clock; all logic is on this one clock
- resetn  in  1  asynchronous assert, active low; shared with the AXI slave
- req_valid  in  NUM_REQ  requester i wants one burst; held until req_ack
- req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  burst start byte address, slice i
- req_ack  out  NUM_REQ  1-cycle pulse when the AW transfer for requester i is accepted
- wr_data  in  NUM_REQ*AXI_DATA_WIDTH  beat data, slice i
- wr_valid  in  NUM_REQ  beat valid, requester i
- wr_ready  out  NUM_REQ  beat accepted (only the granted requester can be high)
- done  out  NUM_REQ  1-cycle pulse when the B response for requester i arrives
- err  out  NUM_REQ  sticky: a burst from requester i got BRESP SLVERR/DECERR
- err_clr  in  NUM_REQ  synchronous clear of err[i]; has priority over a new set
- m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid / m_awready  AXI4 AW channel
- m_wdata, m_wstrb, m_wlast, m_wvalid / m_wready  AXI4 W channel
- m_bresp, m_bvalid / m_bready  AXI4 B channel

## Operation
- State machine states: IDLE, ADDR, DATA, RESP.
- **IDLE:**
  - If any req_valid is set, latch grant = the first set bit at or after the round-robin pointer (searching upward, wrapping).
  - Register m_awaddr from req_addr[grant], with the low log2(BURST_LEN*AXI_DATA_WIDTH/8) bits forced to 0. This keeps every burst naturally aligned and inside a 4 KB boundary.
  - Go to ADDR.
- **ADDR:**
  - m_awvalid=1.
  - On m_awready: pulse req_ack[grant], clear the beat counter, go to DATA.
- **DATA:**
  - Combinational mux:
    - m_wdata = wr_data[grant]
    - m_wvalid = wr_valid[grant]
    - wr_ready[grant] = m_wready
  - m_wstrb is all ones.
  - The beat counter increments on each W handshake.
  - m_wlast = (count == BURST_LEN-1).
  - The handshake on the last beat goes to RESP.
- **RESP:**
  - m_bready=1.
  - On m_bvalid: pulse done[grant]. If m_bresp[1]=1, set err[grant].
  - Set the pointer to grant+1 (wrapping at NUM_REQ). Go to IDLE.
- Fixed AW fields:
  - m_awlen = BURST_LEN-1
  - m_awsize = log2(AXI_DATA_WIDTH/8)
  - m_awburst = INCR
- Only one burst is outstanding at a time. No AW is issued until the previous B response is received.
- A requester that drops req_valid before req_ack is still served if it was already granted: grant is latched in IDLE.
- Simultaneous requests are resolved by the pointer only. A requester that stays asserted waits at most NUM_REQ-1 bursts.
- A stalled requester (wr_valid low) stalls the port. There is no timeout.
- Reset (including mid-burst):
  - State goes to IDLE, the pointer to 0, and err to 0.
  - All valid, ready, ack and done outputs are 0.
  - m_awaddr is 0.
  - The partially written burst is abandoned; the slave is reset together with the arbiter.

## Timing
- req_valid rising in IDLE -> m_awvalid high 1 cycle later, with registered address and fields.
- The AW handshake cycle also produces the req_ack pulse. The first W beat can be accepted in the following cycle.
- The W path is combinational through the grant mux, so there are 0 extra cycles per beat. Full rate is 1 beat/cycle.
- The last W handshake -> m_bready high the next cycle.
- The B handshake -> done pulse in the same cycle (registered at the next edge). IDLE can re-arbitrate in the cycle after the B handshake.
- Minimum burst-to-burst overhead: 3 cycles (IDLE, ADDR, RESP) plus AW and B latency.
- m_awvalid stays high until m_awready. AW fields are stable while m_awvalid is high.

## Structure
- Shared package dsbpm_ddr_pkg holds:
  - the state encoding
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00
  - the clog2 helper for the size and alignment computations
- Sub-module rr_arbiter (NUM_REQ): inputs are the request vector and the pointer; output is the one-hot/indexed grant. It is combinational and reused by other shared-resource blocks.
- Expected size: about 200 lines of RTL.

## Test plan
- Single requester 0 at addr 0x1000_0123, BURST_LEN=16 -> m_awaddr=0x1000_0000, m_awlen=15, m_awsize=5, 16 beats with m_wlast on beat 16, req_ack[0] then done[0], each pulsed once.
- All 4 requesters held valid continuously for 8 bursts -> grant order 0,1,2,3,0,1,2,3; no W beat from a non-granted requester ever reaches m_wdata.
- m_wready toggling 1/0 and wr_valid gaps on beats 3–5 -> exactly 16 handshakes, data order preserved, m_wlast only on the 16th handshake.
- m_bresp=SLVERR on requester 2's burst -> err[2]=1 and stays set; a later OKAY burst leaves it set; err_clr[2] clears it; err_clr and a new error in the same cycle -> err[2]=0.
- m_awready held low for 20 cycles -> m_awvalid and m_awaddr stable throughout, no W activity.
- resetn asserted at beat 7 of a burst -> all outputs 0 immediately; after release, the pointer is 0 and the next request is from requester 0, served normally with a full 16 beats.
